// File: rtl/vga_pkg.sv
// Shared definitions for the programmable palette colour path.
//   - default widths and bank count used by palette_ram and palette_lut_ctrl
//   - slot positions of the R, G and B channels inside a packed palette word
//   - gray-ramp helper that gives every palette entry its power-up colour
package vga_pkg;

    localparam int COLOR_W_DEF = 8;
    localparam int IDX_W_DEF   = 4;
    localparam int NBANK_DEF   = 4;
    localparam int BANK_W_DEF  = 2;

    // A palette word is {R,G,B}: channel slot s occupies bits [s*COLOR_W +: COLOR_W].
    localparam int SLOT_R = 2;
    localparam int SLOT_G = 1;
    localparam int SLOT_B = 0;

    // Gray-ramp channel value for entry idx: the index bits are repeated from
    // the channel MSB downwards (replicated when cw > iw, truncated when cw < iw).
    // With cw=8, iw=4 this gives {idx,idx}, so entry 15 is full white.
    // Result sits in the low cw bits; cw must not exceed 32.
    function automatic logic [31:0] gray_chan(input int idx, input int cw, input int iw);
        logic [31:0] v;
        logic [31:0] ib;
        int          p;
        v  = '0;
        ib = idx;
        for (int k = 0; k < cw; k++) begin
            p    = cw - 1 - k;
            v[k] = ib[iw - 1 - (p % iw)];
        end
        return v;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// Palette storage: NBANK banks of 2^IDX_W entries, each a packed {R,G,B} word.
// Ports:
//   clk, rst             clock, asynchronous active-high reset (loads gray ramp)
//   wr_en/wr_bank/wr_idx/wr_rgb
//                        synchronous write port; banks >= NBANK are ignored
//   rd_bank/rd_idx       combinational read address
//   rd_rgb               entry contents before any write on the current edge
module palette_ram
    import vga_pkg::*;
#(
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int NBANK   = NBANK_DEF,
    parameter int BANK_W  = BANK_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [BANK_W-1:0]      wr_bank,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [3*COLOR_W-1:0]   wr_rgb,
    input  logic [BANK_W-1:0]      rd_bank,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [3*COLOR_W-1:0]   rd_rgb
);

    localparam int              DEPTH   = 1 << IDX_W;
    localparam logic [BANK_W:0] NBANK_L = (BANK_W + 1)'(NBANK);

    logic [3*COLOR_W-1:0] mem_q [NBANK][DEPTH];
    logic [3*COLOR_W-1:0] mem_d [NBANK][DEPTH];

    function automatic logic [COLOR_W-1:0] gray(input int i);
        logic [31:0] t;
        t = gray_chan(i, COLOR_W, IDX_W);
        return t[COLOR_W-1:0];
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (wr_en && ({1'b0, wr_bank} < NBANK_L)) begin
            mem_d[wr_bank][wr_idx] = wr_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[b][i] <= {gray(i), gray(i), gray(i)};
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads see the registered array, so a same-cycle write is not forwarded.
    assign rd_rgb = mem_q[rd_bank][rd_idx];

endmodule

// File: rtl/palette_lut_ctrl.sv
// Programmable palette lookup between the text/attribute pipeline and the DAC.
// Ports:
//   clk, rst                 pixel clock, asynchronous active-high reset
//   pix_valid, pix_fg, fg, bg
//                            pixel in active area, fg/bg select, colour indices
//   vsync                    one-cycle frame-start pulse; bank switches happen here
//   bank_sel                 requested bank, sampled every cycle into a pending reg
//   wr_en/wr_bank/wr_idx/wr_rgb
//                            CPU palette write port ({R,G,B})
//   R, G, B, rgb_valid       colour out, two cycles after the pixel was presented
//   cur_bank                 bank used by lookups this cycle
module palette_lut_ctrl
    import vga_pkg::*;
#(
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int NBANK   = NBANK_DEF,
    parameter int BANK_W  = BANK_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_valid,
    input  logic                   pix_fg,
    input  logic [IDX_W-1:0]       fg,
    input  logic [IDX_W-1:0]       bg,
    input  logic                   vsync,
    input  logic [BANK_W-1:0]      bank_sel,
    input  logic                   wr_en,
    input  logic [BANK_W-1:0]      wr_bank,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [3*COLOR_W-1:0]   wr_rgb,
    output logic [COLOR_W-1:0]     R,
    output logic [COLOR_W-1:0]     G,
    output logic [COLOR_W-1:0]     B,
    output logic                   rgb_valid,
    output logic [BANK_W-1:0]      cur_bank
);

    localparam int              RGB_W   = 3 * COLOR_W;
    localparam logic [BANK_W:0] NBANK_L = (BANK_W + 1)'(NBANK);

    logic [IDX_W-1:0]  rd_idx;
    logic [RGB_W-1:0]  rd_rgb;

    logic [BANK_W-1:0] pend_bank_q, pend_bank_d;
    logic [BANK_W-1:0] cur_bank_q,  cur_bank_d;
    logic [RGB_W-1:0]  s1_rgb_q,    s1_rgb_d;
    logic              s1_vld_q,    s1_vld_d;
    logic [RGB_W-1:0]  out_rgb_q,   out_rgb_d;
    logic              out_vld_q,   out_vld_d;

    palette_ram #(
        .COLOR_W (COLOR_W),
        .IDX_W   (IDX_W),
        .NBANK   (NBANK),
        .BANK_W  (BANK_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_idx  (wr_idx),
        .wr_rgb  (wr_rgb),
        .rd_bank (cur_bank_q),
        .rd_idx  (rd_idx),
        .rd_rgb  (rd_rgb)
    );

    always_comb begin
        rd_idx      = pix_fg ? fg : bg;

        pend_bank_d = bank_sel;
        // cur_bank changes only at the frame boundary, and never to a missing bank,
        // so the RAM read address is always in range.
        cur_bank_d  = cur_bank_q;
        if (vsync && ({1'b0, pend_bank_q} < NBANK_L)) begin
            cur_bank_d = pend_bank_q;
        end

        s1_rgb_d    = rd_rgb;
        s1_vld_d    = pix_valid;

        // Blanking is applied at the output stage so stage 1 stays a plain copy.
        out_vld_d   = s1_vld_q;
        out_rgb_d   = s1_vld_q ? s1_rgb_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_bank_q <= '0;
            cur_bank_q  <= '0;
            s1_rgb_q    <= '0;
            s1_vld_q    <= 1'b0;
            out_rgb_q   <= '0;
            out_vld_q   <= 1'b0;
        end else begin
            pend_bank_q <= pend_bank_d;
            cur_bank_q  <= cur_bank_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_vld_q    <= s1_vld_d;
            out_rgb_q   <= out_rgb_d;
            out_vld_q   <= out_vld_d;
        end
    end

    assign R         = out_rgb_q[SLOT_R*COLOR_W +: COLOR_W];
    assign G         = out_rgb_q[SLOT_G*COLOR_W +: COLOR_W];
    assign B         = out_rgb_q[SLOT_B*COLOR_W +: COLOR_W];
    assign rgb_valid = out_vld_q;
    assign cur_bank  = cur_bank_q;

endmodule

// File: tb/tb_palette_lut_ctrl.sv
// Bench for palette_lut_ctrl: a default build (4 banks) and a 3-bank build share
// all inputs; each has its own reference palette/bank model and expected-output
// queue. Expectations are pushed when a pixel is driven and popped two edges later.
module tb_palette_lut_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid, pix_fg, vsync, wr_en;
    logic [3:0]  fg, bg, wr_idx;
    logic [1:0]  bank_sel, wr_bank;
    logic [23:0] wr_rgb;

    logic [7:0]  r0, g0, b0, r1, g1, b1;
    logic        v0, v1;
    logic [1:0]  cb0, cb1;

    always #5 clk = ~clk;

    palette_lut_ctrl dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_fg(pix_fg), .fg(fg), .bg(bg),
        .vsync(vsync), .bank_sel(bank_sel), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_idx(wr_idx), .wr_rgb(wr_rgb), .R(r0), .G(g0), .B(b0),
        .rgb_valid(v0), .cur_bank(cb0)
    );

    palette_lut_ctrl #(.NBANK(3)) dut3 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_fg(pix_fg), .fg(fg), .bg(bg),
        .vsync(vsync), .bank_sel(bank_sel), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_idx(wr_idx), .wr_rgb(wr_rgb), .R(r1), .G(g1), .B(b1),
        .rgb_valid(v1), .cur_bank(cb1)
    );

    typedef struct {
        logic [24:0] v;
        string       tag;
    } exp_t;

    logic [23:0] pal [2][4][16];
    int          cur [2];
    int          pend [2];
    int          nbk [2];
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic logic [23:0] gray(input int i);
        logic [3:0] n;
        n = i[3:0];
        return {n, n, n, n, n, n};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < 4; b++)
                for (int i = 0; i < 16; i++) pal[m][b][i] = gray(i);
            cur[m]  = 0;
            pend[m] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One pixel clock: drive inputs at the falling edge, update the models,
    // then compare 1 time unit after the rising edge.
    task automatic cyc(input string tag, input logic pv, input logic pfg,
                       input int f, input int b, input logic vs = 1'b0,
                       input logic we = 1'b0, input int wb = 0, input int wi = 0,
                       input logic [23:0] wd = 24'h0);
        int   idx;
        exp_t e;
        @(negedge clk);
        pix_valid = pv;
        pix_fg    = pfg;
        fg        = f[3:0];
        bg        = b[3:0];
        vsync     = vs;
        wr_en     = we;
        wr_bank   = wb[1:0];
        wr_idx    = wi[3:0];
        wr_rgb    = wd;
        idx       = pfg ? f : b;
        for (int m = 0; m < 2; m++) begin
            e.v   = {pv, pv ? pal[m][cur[m]][idx] : 24'h0};
            e.tag = tag;
            if (m == 0) q0.push_back(e);
            else        q1.push_back(e);
            if (we && wb < nbk[m]) pal[m][wb][wi] = wd;
            if (vs && pend[m] < nbk[m]) cur[m] = pend[m];
            pend[m] = int'(bank_sel);
        end
        @(posedge clk);
        #1;
        check({tag, "/cur_bank"},  {23'b0, cb0}, 25'(cur[0]));
        check({tag, "/cur_bank3"}, {23'b0, cb1}, 25'(cur[1]));
        if (q0.size() >= 2) begin
            e = q0.pop_front();
            check({e.tag, "/rgb"}, {v0, r0, g0, b0}, e.v);
        end
        if (q1.size() >= 2) begin
            e = q1.pop_front();
            check({e.tag, "/rgb3"}, {v1, r1, g1, b1}, e.v);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) cyc(tag, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        nbk[0] = 4;
        nbk[1] = 3;
        rst = 1'b1;
        pix_valid = 0; pix_fg = 0; fg = 0; bg = 0; vsync = 0;
        bank_sel = 0; wr_en = 0; wr_bank = 0; wr_idx = 0; wr_rgb = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset/rgb",  {v0, r0, g0, b0, cb0}, 27'h0);
        check("reset/rgb3", {v1, r1, g1, b1, cb1}, 27'h0);
        rst = 1'b0;

        // Gray-ramp defaults
        cyc("dflt_fg5", 1, 1, 5, 0);
        cyc("dflt_bg15", 1, 0, 2, 15);
        cyc("dflt_fg0", 1, 1, 0, 9);
        idle("flush", 2);

        // Write bank 2, select it only at vsync
        cyc("wr_b2i3", 0, 0, 0, 0, 0, 1, 2, 3, 24'h12AB34);
        bank_sel = 2'd2;
        cyc("sel2_novs", 1, 0, 0, 3);
        cyc("sel2_novs2", 1, 0, 0, 3);
        cyc("vs_oldbank", 1, 0, 0, 3, 1);
        cyc("newbank", 1, 0, 0, 3);
        idle("flush", 2);

        // Back to bank 0, then same-cycle write/read hazard
        bank_sel = 2'd0;
        idle("sel0", 1);
        cyc("vs_to0", 0, 0, 0, 0, 1);
        cyc("hazard_old", 1, 1, 7, 0, 0, 1, 0, 7, 24'hFF0000);
        cyc("hazard_new", 1, 1, 7, 0);
        idle("flush", 2);

        // Blanking and back-to-back alternating valid
        cyc("blank_fg15", 0, 1, 15, 0);
        for (int k = 0; k < 8; k++) cyc("alt", k[0], 1, 15 - k, 0);
        idle("flush", 2);

        // Out-of-range bank in the 3-bank build
        cyc("wr_b3i9", 0, 0, 0, 0, 0, 1, 3, 9, 24'hABCDEF);
        cyc("rd_b0i9", 1, 1, 9, 0);
        bank_sel = 2'd3;
        idle("sel3", 2);
        cyc("vs_to3", 0, 0, 0, 0, 1);
        cyc("rd_i9_b3", 1, 1, 9, 0);
        cyc("rd_i9_b3b", 1, 0, 0, 9);
        idle("flush", 2);

        // Mixed traffic: bank_sel held through each frame, vsync at frame end
        for (int fr = 0; fr < 6; fr++) begin
            bank_sel = 2'($urandom_range(0, 3));
            for (int k = 0; k < 8; k++) begin
                cyc("mix", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15), $urandom_range(0, 15), k == 7,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    $urandom_range(0, 15), 24'($urandom));
            end
        end
        idle("flush", 2);

        // Async reset in the middle of active pixels
        cyc("prerst_wr", 1, 1, 4, 0, 0, 1, 0, 7, 24'h00FF00);
        cyc("prerst_a", 1, 1, 15, 0);
        cyc("prerst_b", 1, 1, 15, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst/rgb",  {v0, r0, g0, b0, cb0}, 27'h0);
        check("midrst/rgb3", {v1, r1, g1, b1, cb1}, 27'h0);
        @(negedge clk);
        rst = 1'b0;
        bank_sel = 2'd0;
        model_reset();
        cyc("postrst_i7", 1, 1, 7, 0);
        cyc("postrst_i12", 1, 0, 0, 12);
        idle("flush", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
